fp32_mul_hs_responder: RTL and testbench

//  Multi-cycle IEEE-754 binary32 multiplier and responder end of the EPU a/b/z strobe-ack operand protocol.
//  - Accepts operand A, then operand B, each on its own stb/ack channel.
//  - Computes a*b with round-to-nearest-even.
//  - Returns z on an output stb/ack channel.

---
 rtl/fp32_pkg.sv | 28 ++
 rtl/fp_mant_mul_iter.sv | 74 +++++++
 rtl/fp32_mul_hs_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_fp32_mul_hs_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and the multiplier FSM state encoding.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam int          FP32_BIAS    = 127;
  localparam int          FP32_EXP_MAX = 255;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SUBN,
    SPECIAL,
    MULT,
    NORM,
    DENORM,
    ROUND,
    PACK,
    PUT_Z
  } mul_state_t;

endpackage

// File: rtl/fp_mant_mul_iter.sv
// Iterative 24x24 shift-add mantissa multiplier, MBITS_PER_CYC multiplier bits per cycle.
module fp_mant_mul_iter #(
  parameter int unsigned MBITS_PER_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic        done,
  output logic [47:0] product
);

  localparam int unsigned NCYC = 24 / MBITS_PER_CYC;
  localparam int unsigned CW   = $clog2(NCYC) + 1;

  logic [47:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [23:0]   mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [47:0] src_acc, src_cand, step_acc;
  logic [23:0] src_plier;

  // The start cycle already retires the first digit, so the final digit
  // lands on the edge where done is seen and the caller leaves MULT.
  always_comb begin
    src_acc   = start ? '0 : acc_q;
    src_cand  = start ? {24'b0, a} : mcand_q;
    src_plier = start ? b : mplier_q;
    step_acc  = src_acc;
    for (int unsigned j = 0; j < MBITS_PER_CYC; j++) begin
      if (src_plier[j]) step_acc = step_acc + (src_cand << j);
    end

    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start || busy_q) begin
      acc_d    = step_acc;
      mcand_d  = src_cand << MBITS_PER_CYC;
      mplier_d = src_plier >> MBITS_PER_CYC;
    end
    if (start) begin
      cnt_d  = CW'(NCYC - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = acc_q;

endmodule

// File: rtl/fp32_mul_hs_responder.sv
// Multi-cycle binary32 multiplier (RNE) behind a/b/z strobe-ack handshakes.
// Optional subnormal support: define FP32_MUL_DENORM_EN.
module fp32_mul_hs_responder
  import fp32_pkg::*;
#(
  parameter int unsigned MBITS_PER_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic signed [9:0] BIAS10    = 10'(FP32_BIAS);
  localparam logic signed [9:0] EXP_MAX10 = 10'(FP32_EXP_MAX);

  mul_state_t        state_q, state_d;
  fp32_t             a_q, a_d, b_q, b_d, z_q, z_d;
  logic              sign_q, sign_d;
  logic signed [9:0] ea_q, ea_d, eb_q, eb_d, exp_q, exp_d;
  logic [23:0]       ma_q, ma_d, mb_q, mb_d, mant_q, mant_d;
  logic              g_q, g_d, r_q, r_d, s_q, s_d;

  logic        mul_start, mul_done;
  logic [47:0] product;
  logic [24:0] mant_inc;
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, is_special;

  fp_mant_mul_iter #(.MBITS_PER_CYC(MBITS_PER_CYC)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (ma_q),
    .b       (mb_q),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    a_nan = (a_q.exp == 8'hFF) && (a_q.mant != '0);
    a_inf = (a_q.exp == 8'hFF) && (a_q.mant == '0);
    b_nan = (b_q.exp == 8'hFF) && (b_q.mant != '0);
    b_inf = (b_q.exp == 8'hFF) && (b_q.mant == '0);
`ifdef FP32_MUL_DENORM_EN
    a_zero = (a_q.exp == '0) && (a_q.mant == '0);
    b_zero = (b_q.exp == '0) && (b_q.mant == '0);
`else
    a_zero = (a_q.exp == '0);
    b_zero = (b_q.exp == '0);
`endif
    is_special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    sign_d    = sign_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    exp_d     = exp_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    mant_d    = mant_q;
    g_d       = g_q;
    r_d       = r_q;
    s_d       = s_q;
    mul_start = 1'b0;
    mant_inc  = {1'b0, mant_q} + 25'd1;

    case (state_q)
      GET_A: if (input_a_stb) begin
        a_d     = input_a;
        state_d = GET_B;
      end
      GET_B: if (input_b_stb) begin
        b_d     = input_b;
        state_d = UNPACK;
      end
      UNPACK: begin
        sign_d  = a_q.sign ^ b_q.sign;
        ma_d    = {a_q.exp != '0, a_q.mant};
        mb_d    = {b_q.exp != '0, b_q.mant};
        ea_d    = (a_q.exp == '0) ? 10'sd1 : $signed({2'b00, a_q.exp});
        eb_d    = (b_q.exp == '0) ? 10'sd1 : $signed({2'b00, b_q.exp});
        state_d = SPECIAL;
`ifdef FP32_MUL_DENORM_EN
        if (!is_special && (!ma_d[23] || !mb_d[23])) state_d = SUBN;
`endif
      end
`ifdef FP32_MUL_DENORM_EN
      SUBN: begin
        if (!ma_q[23]) begin
          ma_d = ma_q << 1;
          ea_d = ea_q - 10'sd1;
        end else begin
          mb_d = mb_q << 1;
          eb_d = eb_q - 10'sd1;
        end
        if (ma_d[23] && mb_d[23]) state_d = SPECIAL;
      end
`endif
      SPECIAL: begin
        state_d = PUT_Z;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          z_d = FP32_QNAN;
        end else if (a_inf || b_inf) begin
          z_d = {sign_q, 8'hFF, 23'b0};
        end else if (a_zero || b_zero) begin
          z_d = {sign_q, 31'b0};
        end else begin
          exp_d     = ea_q + eb_q - BIAS10;
          mul_start = 1'b1;
          state_d   = MULT;
        end
      end
      MULT: if (mul_done) state_d = NORM;
      NORM: begin
        if (product[47]) begin
          mant_d = product[47:24];
          g_d    = product[23];
          r_d    = product[22];
          s_d    = |product[21:0];
          exp_d  = exp_q + 10'sd1;
        end else begin
          mant_d = product[46:23];
          g_d    = product[22];
          r_d    = product[21];
          s_d    = |product[20:0];
        end
        state_d = ROUND;
`ifdef FP32_MUL_DENORM_EN
        if (exp_d <= 10'sd0) state_d = DENORM;
`endif
      end
`ifdef FP32_MUL_DENORM_EN
      // Shift into subnormal range before rounding; shifts of 25+ leave nothing.
      DENORM: begin
        if (exp_q <= -10'sd24) begin
          mant_d  = '0;
          g_d     = 1'b0;
          r_d     = 1'b0;
          s_d     = 1'b0;
          exp_d   = 10'sd1;
          state_d = ROUND;
        end else begin
          mant_d = mant_q >> 1;
          g_d    = mant_q[0];
          r_d    = g_q;
          s_d    = s_q || r_q;
          exp_d  = exp_q + 10'sd1;
          if (exp_q == 10'sd0) state_d = ROUND;
        end
      end
`endif
      ROUND: begin
        if (g_q && (r_q || s_q || mant_q[0])) begin
          if (mant_inc[24]) begin
            mant_d = 24'h800000;
            exp_d  = exp_q + 10'sd1;
          end else begin
            mant_d = mant_inc[23:0];
          end
        end
        state_d = PACK;
      end
      PACK: begin
        if (exp_q >= EXP_MAX10) z_d = {sign_q, 8'hFF, 23'b0};
        else if (exp_q <= 10'sd0) z_d = {sign_q, 31'b0};
        else z_d = {sign_q, (mant_q[23] ? exp_q[7:0] : 8'h00), mant_q[22:0]};
        state_d = PUT_Z;
      end
      PUT_Z: if (output_z_ack) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      exp_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      mant_q  <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      exp_q   <= exp_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      mant_q  <= mant_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
    end
  end

  assign input_a_ack  = (state_q == GET_A);
  assign input_b_ack  = (state_q == GET_B);
  assign output_z_stb = (state_q == PUT_Z);
  assign output_z     = z_q;

endmodule

// File: tb/tb_fp32_mul_hs_responder.sv
// Scoreboard bench for fp32_mul_hs_responder: driver pushes expected z/latency, monitor checks on z strobe.
module tb_fp32_mul_hs_responder;

  localparam int unsigned MB    = 2;
  localparam int          LAT_N = 4 + 24 / MB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] input_b = '0;
  logic        input_b_stb = 1'b0;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b1;

  typedef struct {
    logic [31:0] z;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   b_edge = 0;
  logic stb_prev = 1'b0;

  fp32_mul_hs_responder #(.MBITS_PER_CYC(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", name);
  endtask

  task automatic send_a(input logic [31:0] v);
    int n = 0;
    @(negedge clk);
    input_a = v;
    input_a_stb = 1'b1;
    while (!input_a_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!input_a_ack) timeout_fail("a_transfer");
    @(posedge clk);
    #1 input_a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] v);
    int n = 0;
    @(negedge clk);
    input_b = v;
    input_b_stb = 1'b1;
    while (!input_b_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!input_b_ack) timeout_fail("b_transfer");
    b_edge = cyc + 1;
    @(posedge clk);
    #1 input_b_stb = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z, input int lat);
    exp_t e;
    e.z = z;
    e.lat = lat;
    sb.push_back(e);
    send_a(a);
    send_b(b);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || output_z_stb) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || output_z_stb) timeout_fail("drain");
  endtask

  // Monitor: each new z strobe consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stb_prev <= 1'b0;
    end else begin
      if (output_z_stb && !stb_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_z", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("z_value", output_z, e.z);
          if (e.lat != 0) chk("z_latency", 32'(cyc - b_edge), 32'(e.lat));
        end
      end
      stb_prev <= output_z_stb;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ack", {31'b0, input_a_ack}, 32'd1);
    chk("rst_b_ack", {31'b0, input_b_ack}, 32'd0);
    chk("rst_z_stb", {31'b0, output_z_stb}, 32'd0);
    chk("rst_z", output_z, 32'h0);
    rst = 1'b0;

    // Normal products and rounding
    do_op(32'h3F800000, 32'h40000000, 32'h40000000, LAT_N);
    do_op(32'hC0000000, 32'h40400000, 32'hC0C00000, LAT_N);
    do_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, LAT_N);
    do_op(32'h3F800001, 32'h3F800001, 32'h3F800002, LAT_N);
    do_op(32'h3F800003, 32'h3FC00000, 32'h3FC00004, LAT_N);
    do_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, LAT_N);
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, LAT_N);
    // Specials and overflow
    do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 2);
    do_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, LAT_N);
    do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2);
    do_op(32'h3F800000, 32'h7FA00000, 32'h7FC00000, 2);
    do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 2);
    do_op(32'h00000000, 32'hC0000000, 32'h80000000, 2);
    // Underflow and subnormal inputs
`ifdef FP32_MUL_DENORM_EN
    do_op(32'h00800000, 32'h3F000000, 32'h00400000, LAT_N + 1);
    do_op(32'h80800000, 32'h00800000, 32'h80000000, LAT_N + 1);
    do_op(32'h00000001, 32'h3F800000, 32'h00000001, 0);
`else
    do_op(32'h00800000, 32'h3F000000, 32'h00000000, LAT_N);
    do_op(32'h80800000, 32'h00800000, 32'h80000000, LAT_N);
    do_op(32'h00000001, 32'h3F800000, 32'h00000000, 2);
`endif
    drain();

    // Back-pressure on z
    output_z_ack = 1'b0;
    do_op(32'h3F800000, 32'h40400000, 32'h40400000, LAT_N);
    n = 0;
    while (!output_z_stb && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!output_z_stb) timeout_fail("hold_stb_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_stb", {31'b0, output_z_stb}, 32'd1);
      chk("hold_z", output_z, 32'h40400000);
      chk("hold_a_ack", {31'b0, input_a_ack}, 32'd0);
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    chk("post_ack_a_ack", {31'b0, input_a_ack}, 32'd1);
    chk("post_ack_stb", {31'b0, output_z_stb}, 32'd0);

    // Reset during MULT aborts the operation
    do_op(32'h3F800000, 32'h40000000, 32'h40000000, LAT_N);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_a_ack", {31'b0, input_a_ack}, 32'd1);
    chk("midrst_z_stb", {31'b0, output_z_stb}, 32'd0);
    chk("midrst_z", output_z, 32'h0);
    sb.delete();
    rst = 1'b0;
    do_op(32'h40400000, 32'h40400000, 32'h41100000, LAT_N);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
